ifu: RTL and testbench
======================

IFU -- requirements
Module: ifu

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter QDEPTH, default 2: instruction queue entries; legal values 2, 4 or 8.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 im_addr  output  32  byte address presented to instruction memory; always word-aligned.
REQ-006 im_data  input  32  instruction word returned combinationally for im_addr in the same cycle.
REQ-007 inst_valid  output  1  queue head holds a valid instruction.
REQ-008 inst_ready  input  1  consumer (decode) accepts the head this cycle.
REQ-009 inst  output  32  instruction word at queue head.
REQ-010 inst_pc  output  32  fetch address of the instruction at queue head.
REQ-011 redirect  input  1  flush and restart fetch at redirect_pc (branch/jump/exception).
REQ-012 redirect_pc  input  32  new fetch address; bits [1:0] ignored.

Function
REQ-013 ifu SHALL hold a 32-bit fetch PC register; im_addr SHALL equal the PC combinationally, bits [1:0] always 0.
REQ-014 pop SHALL occur when inst_valid and inst_ready are both high on a rising edge.
REQ-015 push SHALL occur on a rising edge when redirect is low and (count < QDEPTH or pop occurs on the same edge); pushed entry = {PC, im_data}.
REQ-016 On each push, PC SHALL advance by 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-017 When full with no pop, no push SHALL occur, PC SHALL hold, and im_addr SHALL remain stable.
REQ-018 Simultaneous push and pop on a full queue SHALL keep count at QDEPTH and preserve order.
REQ-019 Queue SHALL be FIFO: inst/inst_pc SHALL present the oldest entry; inst_valid = (count != 0).
REQ-020 inst and inst_pc SHALL stay stable while inst_valid is high and inst_ready is low.
REQ-021 redirect high on an edge SHALL clear the queue (count = 0), suppress the push, and load PC with {redirect_pc[31:2], 2'b00}; a handshake in that cycle is treated as consumed.
REQ-022 redirect SHALL take priority over push and pop on the same edge.
REQ-023 Fetch-to-issue latency SHALL be one cycle: an instruction fetched at edge N SHALL be at the queue head after edge N when the queue was empty.
REQ-024 After a redirect at edge N, inst_valid SHALL be high after edge N+1 with inst_pc = redirect target.
REQ-025 Sustained throughput SHALL be one instruction per cycle while inst_ready stays high.
REQ-026 Queue pointers SHALL wrap modulo QDEPTH; count SHALL never exceed QDEPTH nor underflow.

Reset
REQ-027 While rst is high: PC = RESET_PC, count = 0, pointers = 0, inst_valid = 0, im_addr = RESET_PC.
REQ-028 inst and inst_pc SHALL read 32'h0 while rst is high.
REQ-029 rst asserted mid-operation SHALL discard all queued entries immediately, without waiting for clk.
REQ-030 First push SHALL occur on the first rising edge after rst deasserts.

Structure
REQ-031 The shared package/header SHALL hold the word width (32), instruction-increment constant (4) and default RESET_PC.
REQ-032 The queue SHALL be a sub-module ifu_fifo (parameterised width and depth, push/pop/flush, count, head read), instantiated once with width 64 ({pc, inst}).
REQ-033 PC, push/pop and redirect control SHALL live in ifu; ifu_fifo SHALL contain no fetch logic.

Verification
REQ-034 Reset release with inst_ready=1 and memory word i = 32'h1000_0000+i -> inst_pc 0,4,8,... one per cycle, inst matches word i.
REQ-035 inst_ready=0 for 5 cycles after reset (QDEPTH=2) -> count saturates at 2, im_addr holds 32'h8, inst_pc stays 0; on release, PCs 0,4,8 issue in order with no gap.
REQ-036 redirect=1, redirect_pc=32'h0000_0043 with a full queue -> queue empty next cycle, im_addr = 32'h40, then inst_pc = 32'h40 the following cycle.
REQ-037 RESET_PC=32'hFFFF_FFF8, inst_ready=1 -> inst_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
REQ-038 rst asserted asynchronously between edges with 2 entries queued -> inst_valid falls before the next edge; im_addr = RESET_PC.
REQ-039 Random inst_ready toggling over 1000 cycles -> issued inst_pc strictly sequential by 4, no loss, no duplication.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit.
//   XLEN             : word / address width
//   INST_INC         : byte step between consecutive instructions
//   DEFAULT_RESET_PC : default first fetch address after reset
//   fetch_entry_t    : one queue entry, {pc, inst}
//   word_align()     : clears the byte-offset bits of an address
package ifu_pkg;
  localparam int          XLEN             = 32;
  localparam logic [31:0] INST_INC         = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & ~32'h3;
  endfunction
endpackage

// File: rtl/ifu_if.sv
// Fetch-side bus: instruction memory port, issue handshake towards decode,
// and the redirect request from the back end.
//   master : the fetch unit (drives im_addr and the issue outputs)
//   slave  : memory + decode + redirect source
interface ifu_if import ifu_pkg::*; ();
  logic [XLEN-1:0] im_addr;
  logic [XLEN-1:0] im_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output im_addr, inst_valid, inst, inst_pc,
    input  im_data, inst_ready, redirect, redirect_pc
  );

  modport slave (
    input  im_addr, inst_valid, inst, inst_pc,
    output im_data, inst_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/ifu_fifo.sv
// Generic synchronous FIFO used as the fetch instruction queue.
//   clk/rst : clock, async active-high reset (empties the queue)
//   push    : write wdata at the tail (ignored when full unless popping)
//   pop     : drop the head (ignored when empty)
//   flush   : empty the queue; wins over push and pop
//   rdata   : head entry, reads zero when empty
//   count   : number of valid entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module ifu_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full, do_push, do_pop;

  always_comb begin
    full    = (count_q == CW'(DEPTH));
    do_pop  = pop & (count_q != '0);
    // A pop on the same edge frees the slot, so a full queue can still accept.
    do_push = push & (~full | do_pop);

    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count = count_q;
endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: holds the fetch PC, reads one word per cycle from
// a combinational instruction memory, and queues {pc, inst} for decode.
//   clk/rst : clock, async active-high reset
//   bus     : ifu_if.master -- im_addr/im_data memory port,
//             inst_valid/inst_ready/inst/inst_pc issue handshake,
//             redirect/redirect_pc flush-and-restart request
module ifu import ifu_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              QDEPTH   = 2
) (
  input  logic   clk,
  input  logic   rst,
  ifu_if.master  bus
);
  localparam int CW = $clog2(QDEPTH) + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   count;
  logic            full, pop, push;
  fetch_entry_t    wentry, head;

  assign full = (count == CW'(QDEPTH));
  assign pop  = bus.inst_valid & bus.inst_ready;
  // Redirect squashes the word fetched from the stale PC.
  assign push = ~bus.redirect & (~full | pop);

  always_comb begin
    pc_d = pc_q;
    if (bus.redirect)  pc_d = word_align(bus.redirect_pc);
    else if (push)     pc_d = pc_q + INST_INC;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  assign wentry.pc   = pc_q;
  assign wentry.inst = bus.im_data;

  ifu_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wentry),
    .pop   (pop),
    .flush (bus.redirect),
    .rdata (head),
    .count (count)
  );

  assign bus.im_addr    = word_align(pc_q);
  assign bus.inst_valid = (count != '0);
  // Head reads zero while empty, which covers the reset-time requirement.
  assign bus.inst       = head.inst;
  assign bus.inst_pc    = head.pc;
endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu. Two instances share clock, reset and the
// decode/redirect inputs: dut0 uses the defaults, dut1 starts near the top
// of the address space with a deeper queue. A shift-array queue model
// predicts the head and the fetch address of each instance every cycle.
module tb_ifu;
  logic        clk, rst, ready, redirect;
  logic [31:0] rpc;
  int          n_chk, n_err;

  ifu_if b0 ();
  ifu_if b1 ();

  ifu #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  ifu #(.RESET_PC(32'hFFFF_FFF8), .QDEPTH(4)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  assign b0.im_data = mem_word(b0.im_addr);
  assign b1.im_data = mem_word(b1.im_addr);
  assign b0.inst_ready = ready;        assign b1.inst_ready = ready;
  assign b0.redirect = redirect;       assign b1.redirect = redirect;
  assign b0.redirect_pc = rpc;         assign b1.redirect_pc = rpc;

  logic        ov [2];
  logic [31:0] oa [2], opc [2], oi [2];
  assign ov[0] = b0.inst_valid; assign oa[0] = b0.im_addr;
  assign opc[0] = b0.inst_pc;   assign oi[0] = b0.inst;
  assign ov[1] = b1.inst_valid; assign oa[1] = b1.im_addr;
  assign opc[1] = b1.inst_pc;   assign oi[1] = b1.inst;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: queued PCs kept oldest-first, popped by shifting.
  localparam int          DEP  [2] = '{2, 4};
  localparam logic [31:0] RPCS [2] = '{32'h0000_0000, 32'hFFFF_FFF8};
  logic [31:0] mq [2][8];
  int          mcnt [2];
  logic [31:0] mpc [2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mcnt[d] = 0;
      mpc[d]  = RPCS[d];
    end
  endtask

  task automatic model_edge();
    bit pop, push;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        mcnt[d] = 0;
        mpc[d]  = RPCS[d];
      end else if (redirect) begin
        mcnt[d] = 0;
        mpc[d]  = rpc & 32'hFFFF_FFFC;
      end else begin
        pop  = (mcnt[d] != 0) && ready;
        push = (mcnt[d] < DEP[d]) || pop;
        if (pop) begin
          for (int i = 0; i < 7; i++) mq[d][i] = mq[d][i+1];
          mcnt[d]--;
        end
        if (push) begin
          mq[d][mcnt[d]] = mpc[d];
          mcnt[d]++;
          mpc[d] = mpc[d] + 32'd4;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d_valid", d), 64'(ov[d]), 64'(mcnt[d] != 0));
      chk($sformatf("d%0d_im_addr", d), 64'(oa[d]), 64'(mpc[d]));
      if (mcnt[d] != 0) begin
        chk($sformatf("d%0d_inst_pc", d), 64'(opc[d]), 64'(mq[d][0]));
        chk($sformatf("d%0d_inst", d), 64'(oi[d]), 64'(mem_word(mq[d][0])));
      end
    end
  endtask

  // Inputs are already set; apply one rising edge and check after it.
  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  logic [31:0] exp_next;

  initial begin
    n_chk = 0; n_err = 0;
    rst = 1'b1; ready = 1'b0; redirect = 1'b0; rpc = '0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_inst%0d", d), 64'(oi[d]), 64'h0);
      chk($sformatf("rst_pc%0d", d), 64'(opc[d]), 64'h0);
    end

    // Streaming from reset, one per cycle; dut1 wraps through zero.
    rst = 1'b0; ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      logic [31:0] w1;
      step();
      w1 = 32'hFFFF_FFF8 + 32'(4 * (k - 1));
      chk("stream_pc0", 64'(opc[0]), 64'(32'(4 * (k - 1))));
      chk("stream_inst0", 64'(oi[0]), 64'(32'h1000_0000 + 32'(k - 1)));
      chk("wrap_pc1", 64'(opc[1]), 64'(w1));
    end

    // Back-pressure after reset: queue saturates, fetch address holds.
    rst = 1'b1; model_reset();
    @(negedge clk);
    rst = 1'b0; ready = 1'b0;
    repeat (5) step();
    chk("stall_addr", 64'(oa[0]), 64'h8);
    chk("stall_pc", 64'(opc[0]), 64'h0);
    ready = 1'b1;
    step(); chk("rel_pc4", 64'(opc[0]), 64'h4); chk("rel_v4", 64'(ov[0]), 64'h1);
    step(); chk("rel_pc8", 64'(opc[0]), 64'h8); chk("rel_v8", 64'(ov[0]), 64'h1);

    // Redirect with a full queue to an unaligned target.
    ready = 1'b0;
    repeat (3) step();
    redirect = 1'b1; rpc = 32'h0000_0043;
    step();
    chk("redir_addr", 64'(oa[0]), 64'h40);
    chk("redir_empty", 64'(ov[0]), 64'h0);
    redirect = 1'b0;
    step();
    chk("redir_pc", 64'(opc[0]), 64'h40);
    chk("redir_valid", 64'(ov[0]), 64'h1);

    // Asynchronous reset between edges with two entries queued.
    step();
    chk("two_queued", 64'(mcnt[0]), 64'd2);
    #2 rst = 1'b1;
    #1;
    chk("async_v0", 64'(ov[0]), 64'h0);
    chk("async_v1", 64'(ov[1]), 64'h0);
    chk("async_a0", 64'(oa[0]), 64'h0);
    chk("async_a1", 64'(oa[1]), 64'hFFFF_FFF8);
    model_reset();
    @(negedge clk);
    compare_all();
    rst = 1'b0;

    // Random back-pressure with occasional redirects; the issued stream of
    // dut0 must step by 4 from each restart point.
    exp_next = 32'h0;
    for (int c = 0; c < 1000; c++) begin
      ready    = 1'($urandom_range(0, 1));
      redirect = ($urandom_range(0, 49) == 0);
      rpc      = $urandom;
      if (ov[0] && ready) begin
        chk("issue_seq", 64'(opc[0]), 64'(exp_next));
        exp_next = exp_next + 32'd4;
      end
      if (redirect) exp_next = rpc & 32'hFFFF_FFFC;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
